// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin select arbiter and its mux tests.
package rr_arb_pkg;

  localparam int unsigned RR_ARB_N_DEFAULT = 4;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Binary index of a one-hot vector; an all-zero vector maps to 0.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) r = r | i;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: rotate by ptr, find first set bit, unrotate.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N     = RR_ARB_N_DEFAULT,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     pick_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [N-1:0] rot;
  logic [N-1:0] first;
  logic         found;
  int unsigned  ptr_u;

  always_comb begin
    ptr_u  = 32'(ptr_i);
    rot    = '0;
    first  = '0;
    found  = 1'b0;
    pick_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rot[i] = req_i[IDX_W'((i + ptr_u) % N)];
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        first[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (first[i]) pick_o[IDX_W'((i + ptr_u) % N)] = 1'b1;
    end
    idx_o = IDX_W'(onehot_to_idx(32'(pick_o)));
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing a registered one-hot mux select held until done_i.
// Optional hold watchdog enabled by defining RR_ARB_TIMEOUT_EN.
module rr_sel_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N        = RR_ARB_N_DEFAULT,
  parameter int unsigned IDX_W    = $clog2(N),
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             done_i,
  output logic [N-1:0]     gnt_o,
  output logic             gnt_valid_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             timeout_o
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [N-1:0]     pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             grant_load;
  logic             wd_expire;
  logic             release_now;

  rr_arb_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i  (req_i),
    .ptr_i  (pick_ptr),
    .pick_o (pick_oh),
    .idx_o  (pick_idx)
  );

  assign ptr_next = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);

  // On a release the pick already uses the advanced pointer, giving a bubble-free regrant.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    idx_d       = idx_q;
    pick_ptr    = ptr_q;
    grant_load  = 1'b0;
    release_now = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|req_i) begin
          gnt_d      = pick_oh;
          idx_d      = pick_idx;
          grant_load = 1'b1;
          state_d    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        release_now = done_i | wd_expire;
        if (release_now) begin
          ptr_d    = ptr_next;
          pick_ptr = ptr_next;
          if (|req_i) begin
            gnt_d      = pick_oh;
            idx_d      = pick_idx;
            grant_load = 1'b1;
          end else begin
            gnt_d   = '0;
            idx_d   = '0;
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q;

  // hold_q counts BUSY cycles already elapsed, so expiry fires in the MAX_HOLD-th one.
  assign wd_expire = (state_q == ARB_BUSY) && (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    hold_d = '0;
    if (!grant_load && state_q == ARB_BUSY) hold_d = hold_q + HOLD_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= wd_expire & ~done_i;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = |gnt_q;
  assign gnt_idx_o   = idx_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_rr_sel_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 15;

  logic         clk;
  logic         rst_i;
  logic [N-1:0] req_i;
  logic         done_i;
  logic [N-1:0] gnt_o;
  logic         gnt_valid_o;
  logic [1:0]   gnt_idx_o;
  logic         timeout_o;

  int checks;
  int errors;

  // Reference model state
  bit m_busy;
  int m_ptr;
  int m_win;
  int m_age;
  bit m_tmo;

  rr_sel_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .done_i      (done_i),
    .gnt_o       (gnt_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_idx_o   (gnt_idx_o),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_busy) g[m_win] = 1'b1;
    return g;
  endfunction

  function automatic logic [1:0] exp_idx();
    return m_busy ? 2'(m_win) : 2'd0;
  endfunction

  // Drive one cycle from a negedge, let the edge happen, advance the model, return at negedge.
  task automatic cycle(input logic [N-1:0] r, input logic d, input logic rs);
    bit expire;
    req_i  = r;
    done_i = d;
    rst_i  = rs;
    @(posedge clk);
    m_tmo = 1'b0;
    if (rs) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      m_win  = 0;
      m_age  = 0;
    end else if (!m_busy) begin
      if (r != '0) begin
        m_win  = first_from(r, m_ptr);
        m_busy = 1'b1;
        m_age  = 0;
      end
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      expire = (m_age == MAX_HOLD - 1);
`else
      expire = 1'b0;
`endif
      if (d || expire) begin
        m_tmo = expire && !d;
        m_ptr = (m_win + 1) % N;
        if (r != '0) begin
          m_win = first_from(r, m_ptr);
          m_age = 0;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_age++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle('0, 1'b0, 1'b1);
    checks++;
    if (gnt_o !== 4'b0000 || gnt_valid_o !== 1'b0 || gnt_idx_o !== 2'd0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: gnt=%b valid=%b idx=%0d tmo=%b required 0000/0/0/0",
               gnt_o, gnt_valid_o, gnt_idx_o, timeout_o);
    end
  endtask

  task automatic test_first_grant();
    cycle('0, 1'b0, 1'b0);
    cycle(4'b1010, 1'b0, 1'b0);
    checks++;
    if (gnt_o !== 4'b0010 || gnt_idx_o !== 2'd1 || gnt_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: gnt=%b idx=%0d valid=%b required 0010/1/1",
               gnt_o, gnt_idx_o, gnt_valid_o);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    cycle('0, 1'b0, 1'b1);
    cycle(4'b1111, 1'b0, 1'b0);
    checks++;
    if (gnt_o !== seq[0]) begin
      errors++;
      $display("FAIL rotation_start: gnt=%b required %b", gnt_o, seq[0]);
    end
    for (int g = 1; g < 5; g++) begin
      for (int h = 0; h < 2; h++) begin
        cycle(4'b1111, 1'b0, 1'b0);
        checks++;
        if (gnt_o !== seq[g-1]) begin
          errors++;
          $display("FAIL rotation_hold[%0d]: gnt=%b required %b", g, gnt_o, seq[g-1]);
        end
      end
      cycle(4'b1111, 1'b1, 1'b0);
      checks++;
      if (gnt_o !== seq[g]) begin
        errors++;
        $display("FAIL rotation_step[%0d]: gnt=%b required %b", g, gnt_o, seq[g]);
      end
    end
  endtask

  task automatic test_grant_lock();
    cycle('0, 1'b0, 1'b1);
    cycle(4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0001, 1'b0, 1'b0);
      checks++;
      if (gnt_o !== 4'b0100) begin
        errors++;
        $display("FAIL grant_lock[%0d]: gnt=%b required 0100", i, gnt_o);
      end
    end
    cycle(4'b0001, 1'b1, 1'b0);
    checks++;
    if (gnt_o !== 4'b0001 || gnt_idx_o !== 2'd0) begin
      errors++;
      $display("FAIL grant_lock_release: gnt=%b idx=%0d required 0001/0", gnt_o, gnt_idx_o);
    end
  endtask

  task automatic test_idle_return();
    cycle('0, 1'b1, 1'b0);
    checks++;
    if (gnt_o !== 4'b0000 || gnt_valid_o !== 1'b0 || gnt_idx_o !== 2'd0) begin
      errors++;
      $display("FAIL idle_return: gnt=%b valid=%b idx=%0d required 0000/0/0",
               gnt_o, gnt_valid_o, gnt_idx_o);
    end
    cycle('0, 1'b1, 1'b0);
    checks++;
    if (gnt_o !== 4'b0000) begin
      errors++;
      $display("FAIL idle_done_ignored: gnt=%b required 0000", gnt_o);
    end
    cycle(4'b1000, 1'b0, 1'b0);
    checks++;
    if (gnt_o !== 4'b1000 || gnt_idx_o !== 2'd3) begin
      errors++;
      $display("FAIL idle_regrant: gnt=%b idx=%0d required 1000/3", gnt_o, gnt_idx_o);
    end
  endtask

  task automatic test_reset_mid();
    cycle('0, 1'b0, 1'b1);
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0100, 1'b1, 1'b0);
    checks++;
    if (gnt_o !== 4'b0100) begin
      errors++;
      $display("FAIL reset_mid_setup: gnt=%b required 0100", gnt_o);
    end
    cycle(4'b1111, 1'b0, 1'b1);
    checks++;
    if (gnt_o !== 4'b0000 || gnt_valid_o !== 1'b0 || gnt_idx_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_drop: gnt=%b valid=%b idx=%0d required 0000/0/0",
               gnt_o, gnt_valid_o, gnt_idx_o);
    end
    cycle(4'b1111, 1'b0, 1'b0);
    checks++;
    if (gnt_o !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_ptr: gnt=%b required 0001", gnt_o);
    end
  endtask

`ifdef RR_ARB_TIMEOUT_EN
  task automatic test_watchdog();
    for (int run = 0; run < 2; run++) begin
      cycle('0, 1'b0, 1'b1);
      cycle(4'b0001, 1'b0, 1'b0);
      for (int c = 1; c < MAX_HOLD; c++) begin
        cycle(4'b1111, 1'b0, 1'b0);
        checks++;
        if (gnt_o !== 4'b0001 || timeout_o !== 1'b0) begin
          errors++;
          $display("FAIL watchdog_hold[%0d/%0d]: gnt=%b tmo=%b required 0001/0",
                   run, c, gnt_o, timeout_o);
        end
      end
      cycle(4'b1111, (run == 1), 1'b0);
      checks++;
      if (gnt_o !== 4'b0010 || timeout_o !== (run == 0)) begin
        errors++;
        $display("FAIL watchdog_fire[%0d]: gnt=%b tmo=%b required 0010/%0d",
                 run, gnt_o, timeout_o, (run == 0));
      end
      cycle(4'b1111, 1'b0, 1'b0);
      checks++;
      if (timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL watchdog_pulse[%0d]: tmo=%b required 0", run, timeout_o);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] r;
    logic         d;
    logic         rs;
    cycle('0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      r  = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = '0;
      d  = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 60) == 0);
      cycle(r, d, rs);
      checks++;
      if (gnt_o !== exp_gnt() || gnt_idx_o !== exp_idx() || gnt_valid_o !== m_busy ||
          timeout_o !== m_tmo) begin
        errors++;
        $display("FAIL random[%0d]: gnt=%b idx=%0d valid=%b tmo=%b required %b/%0d/%b/%b",
                 i, gnt_o, gnt_idx_o, gnt_valid_o, timeout_o,
                 exp_gnt(), exp_idx(), m_busy, m_tmo);
      end
      checks++;
      if ($countones(gnt_o) > 1) begin
        errors++;
        $display("FAIL random_onehot[%0d]: gnt=%b required at most one bit set", i, gnt_o);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_busy = 1'b0;
    m_ptr  = 0;
    m_win  = 0;
    m_age  = 0;
    m_tmo  = 1'b0;
    rst_i  = 1'b1;
    req_i  = '0;
    done_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_grant();
    test_rotation();
    test_grant_lock();
    test_idle_return();
    test_reset_mid();
`ifdef RR_ARB_TIMEOUT_EN
    test_watchdog();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
